// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file command sequencer.
// Op encodings, FSM states, access phases and register indices.
package regfile_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_SWAP  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR_A,
    S_WR_B,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_RD,
    PH_WR
  } phase_t;

  localparam logic [2:0] AX = 3'd0;
  localparam logic [2:0] BX = 3'd1;
  localparam logic [2:0] CX = 3'd2;
  localparam logic [2:0] DX = 3'd3;
  localparam logic [2:0] SP = 3'd4;
  localparam logic [2:0] BP = 3'd5;
  localparam logic [2:0] DI = 3'd6;
  localparam logic [2:0] SI = 3'd7;

endpackage

// File: rtl/regfile_seq_ctrl_decode.sv
// Maps an access phase and register index onto register-file port strobes.
// idx[2] picks the general (rd1) or pointer/index (rd2) read port.
module rf_port_decode
  import regfile_pkg::*;
(
  input  logic [1:0] phase,
  input  logic [2:0] idx,
  output logic       rd1,
  output logic       rd2,
  output logic       wr,
  output logic [1:0] sel
);

  always_comb begin
    rd1 = 1'b0;
    rd2 = 1'b0;
    wr  = 1'b0;
    sel = 2'b00;
    unique case (1'b1)
      (phase == PH_RD): begin
        rd1 = ~idx[2];
        rd2 = idx[2];
        sel = idx[1:0];
      end
      (phase == PH_WR): begin
        wr  = 1'b1;
        sel = idx[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Sequencer expanding READ/WRITE/MOVE/SWAP commands into
// register-file strobe sequences with a valid/ready response.
module regfile_seq_ctrl
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [2:0]    cmd_dst,
  input  logic [2:0]    cmd_src,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          rf_en,
  output logic          rf_wr,
  output logic          rf_rd1,
  output logic          rf_rd2,
  output logic [1:0]    rf_sel,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_rdata,
  output logic [7:0]    err_count
);

  state_t        state;
  state_t        next;
  op_t           op_q;
  logic [2:0]    dst_q;
  logic [2:0]    src_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] tmp_a;
  logic [DW-1:0] tmp_b;
  logic          err_q;
  logic          accept;
  logic          cmd_err;
  logic [1:0]    phase;
  logic [2:0]    idx;

  assign accept = cmd_valid && cmd_ready;

  // Pointer-group registers are read-only through this port.
  assign cmd_err = ((cmd_op != OP_READ) && cmd_dst[2])
                || ((cmd_op == OP_SWAP) && cmd_src[2]);

  always_comb begin
    next     = state;
    phase    = PH_NONE;
    idx      = 3'd0;
    rf_wdata = '0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_err)
            next = S_RESP;
          else if (cmd_op == OP_WRITE)
            next = S_WR_A;
          else
            next = S_RD_A;
        end
      end
      S_RD_A: begin
        phase = PH_RD;
        idx   = (op_q == OP_READ) ? dst_q : src_q;
        if (op_q == OP_SWAP)
          next = S_RD_B;
        else if (op_q == OP_MOVE)
          next = S_WR_A;
        else
          next = S_RESP;
      end
      S_RD_B: begin
        phase = PH_RD;
        idx   = dst_q;
        next  = S_WR_A;
      end
      S_WR_A: begin
        phase    = PH_WR;
        idx      = dst_q;
        rf_wdata = (op_q == OP_WRITE) ? data_q : tmp_a;
        next     = (op_q == OP_SWAP) ? S_WR_B : S_RESP;
      end
      S_WR_B: begin
        phase    = PH_WR;
        idx      = src_q;
        rf_wdata = tmp_b;
        next     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready)
          next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  rf_port_decode u_decode (
    .phase (phase),
    .idx   (idx),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .wr    (rf_wr),
    .sel   (rf_sel)
  );

  assign rf_en = (phase != PH_NONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      op_q      <= OP_READ;
      dst_q     <= 3'd0;
      src_q     <= 3'd0;
      data_q    <= '0;
      tmp_a     <= '0;
      tmp_b     <= '0;
      err_q     <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= next;
      cmd_ready <= (next == S_IDLE);
      if (accept) begin
        op_q   <= op_t'(cmd_op);
        dst_q  <= cmd_dst;
        src_q  <= cmd_src;
        data_q <= cmd_data;
        err_q  <= cmd_err;
        if (cmd_err && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
      end
      if (state == S_RD_A)
        tmp_a <= rf_rdata;
      if (state == S_RD_B)
        tmp_b <= rf_rdata;
    end
  end

  always_comb begin
    rsp_valid = (state == S_RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_data  = '0;
    if (rsp_valid && !err_q) begin
      unique case (op_q)
        OP_WRITE: rsp_data = data_q;
        OP_SWAP:  rsp_data = tmp_b;
        default:  rsp_data = tmp_a;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Self-checking bench: register-file stub, strobe monitor and a
// command-level reference model driven by directed and random commands.
module tb_regfile_seq_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [2:0]    cmd_dst;
  logic [2:0]    cmd_src;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rf_en;
  logic          rf_wr;
  logic          rf_rd1;
  logic          rf_rd2;
  logic [1:0]    rf_sel;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_seq_ctrl #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src   (cmd_src),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rf_en     (rf_en),
    .rf_wr     (rf_wr),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .rf_sel    (rf_sel),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .err_count (err_count)
  );

  // Register file stub: general group writable, pointer group fixed.
  logic [DW-1:0] gen [4];
  logic [DW-1:0] ptr [4];

  always @(posedge clk)
    if (rf_en && rf_wr) gen[rf_sel] <= rf_wdata;

  assign rf_rdata = rf_rd1 ? gen[rf_sel] : (rf_rd2 ? ptr[rf_sel] : '0);

  // Strobe monitor: cumulative counts, sampled mid-cycle.
  int n_en = 0;
  int n_rd1 = 0;
  int n_rd2 = 0;
  int n_wr = 0;
  int bad = 0;
  logic [1:0] rd_sel = 2'b00;
  logic [1:0] wr_sel = 2'b00;

  always @(negedge clk) begin
    if (rf_en) n_en++;
    if (rf_rd1) n_rd1++;
    if (rf_rd2) n_rd2++;
    if (rf_wr) n_wr++;
    if (rf_rd1 || rf_rd2) rd_sel = rf_sel;
    if (rf_wr) wr_sel = rf_sel;
    if (rf_en && (int'(rf_rd1) + int'(rf_rd2) + int'(rf_wr)) != 1) bad++;
    if (!rf_en && (rf_rd1 || rf_rd2 || rf_wr)) bad++;
  end

  // Reference model state.
  logic [DW-1:0] m [8];
  int m_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [2:0] d,
                       input logic [2:0] s, input logic [DW-1:0] data,
                       output logic [DW-1:0] ed, output logic ee,
                       output int el, output int erd, output int ewr);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    ee = (op != 2'd0 && d >= 3'd4) || (op == 2'd3 && s >= 3'd4);
    ed = '0;
    el = 1;
    erd = 0;
    ewr = 0;
    if (ee) begin
      if (m_err < 255) m_err++;
    end else begin
      case (op)
        2'd0: begin ed = m[d]; el = 2; erd = 1; end
        2'd1: begin m[d] = data; ed = data; el = 2; ewr = 1; end
        2'd2: begin
          ed = m[s]; m[d] = m[s]; el = 3; erd = 1; ewr = 1;
        end
        default: begin
          a = m[s]; b = m[d];
          m[d] = a; m[s] = b;
          ed = b; el = 5; erd = 2; ewr = 2;
        end
      endcase
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [2:0] d,
                     input logic [2:0] s, input logic [DW-1:0] data,
                     input int hold);
    logic [DW-1:0] ed;
    logic ee;
    int el, erd, ewr, lat, w;
    int b_en, b_rd, b_wr;
    model(op, d, s, data, ed, ee, el, erd, ewr);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_wait", cmd_ready, 1);
    b_en = n_en;
    b_rd = n_rd1 + n_rd2;
    b_wr = n_wr;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_dst = d;
    cmd_src = s;
    cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_dst = 3'($urandom);
    cmd_src = 3'($urandom);
    cmd_data = DW'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, el);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_err", rsp_err, ee);
    chk("err_count", err_count, m_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_err", rsp_err, ee);
      chk("hold_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", cmd_ready, 1);
    chk("n_en", n_en - b_en, erd + ewr);
    chk("n_rd", n_rd1 + n_rd2 - b_rd, erd);
    chk("n_wr", n_wr - b_wr, ewr);
  endtask

  initial begin
    int b1, b2;
    logic [1:0] op;
    logic [2:0] d, s;
    rst = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_op = 2'd0;
    cmd_dst = 3'd0;
    cmd_src = 3'd0;
    cmd_data = '0;
    for (int i = 0; i < 4; i++) begin
      ptr[i] = DW'($urandom);
      m[4 + i] = ptr[i];
    end
    #12;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_en", rf_en, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_errcnt", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    chk("ready_rise", cmd_ready, 1);

    run(2'd1, 3'd0, 3'd0, 16'h1234, 0);
    run(2'd0, 3'd0, 3'd0, 16'h0000, 0);
    run(2'd1, 3'd1, 3'd0, DW'($urandom), 0);
    run(2'd1, 3'd2, 3'd0, DW'($urandom), 0);
    run(2'd1, 3'd3, 3'd0, DW'($urandom), 0);

    b1 = n_rd1;
    run(2'd2, 3'd3, 3'd0, 16'h0000, 0);
    chk("move_rd1", n_rd1 - b1, 1);
    chk("move_wsel", wr_sel, 3);
    chk("move_dx", gen[3], 16'h1234);

    run(2'd1, 3'd0, 3'd0, 16'h00AA, 0);
    run(2'd1, 3'd1, 3'd0, 16'h00BB, 0);
    run(2'd3, 3'd1, 3'd0, 16'h0000, 1);
    chk("swap_ax", gen[0], 16'h00BB);
    chk("swap_bx", gen[1], 16'h00AA);
    run(2'd3, 3'd2, 3'd2, 16'h0000, 0);

    run(2'd1, 3'd5, 3'd0, 16'hBEEF, 0);
    chk("err_one", err_count, 1);

    b2 = n_rd2;
    run(2'd0, 3'd6, 3'd0, 16'h0000, 4);
    chk("rd2_cnt", n_rd2 - b2, 1);
    chk("rd2_sel", rd_sel, 2);

    for (int i = 0; i < 120; i++) begin
      op = 2'($urandom);
      d = 3'($urandom);
      s = 3'($urandom);
      run(op, d, s, DW'($urandom), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 4; i++) chk("rf_state", gen[i], m[i]);

    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    cmd_dst = 3'd3;
    cmd_src = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rdb_rd1", rf_rd1, 1);
    rst = 1'b1;
    #1;
    chk("arst_en", rf_en, 0);
    chk("arst_rd1", rf_rd1, 0);
    chk("arst_rd2", rf_rd2, 0);
    chk("arst_wr", rf_wr, 0);
    chk("arst_sel", rf_sel, 0);
    chk("arst_wdata", rf_wdata, 0);
    chk("arst_valid", rsp_valid, 0);
    chk("arst_ready", cmd_ready, 0);
    m_err = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("arst_hold", cmd_ready, 0);
    @(posedge clk); #1;
    chk("arst_rise", cmd_ready, 1);
    for (int i = 0; i < 4; i++) chk("no_rollbk", gen[i], m[i]);

    for (int i = 0; i < 256; i++) run(2'd1, 3'd5, 3'd0, 16'h5555, 0);
    chk("err_sat", err_count, 8'd255);
    chk("strobe_excl", bad, 0);
    for (int i = 0; i < 4; i++) chk("rf_final", gen[i], m[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_seq_ctrl.md
# regfile_seq_ctrl

Command sequencer that owns the control port of the 8 × 16-bit register file (AX, BX, CX, DX general group; SP, BP, DI, SI pointer/index group). It accepts one register-transfer command at a time: READ, WRITE, MOVE or SWAP. It expands each command into a cycle-by-cycle sequence of register-file enable, read, write and select strobes, then returns a response through a valid/ready handshake. It sits between the instruction-level control path and the register file, so that no other block drives the register-file strobes.

## Interface
- `DW`, 16, data width of registers and command/response data.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  00 READ, 01 WRITE, 10 MOVE, 11 SWAP.
- `cmd_dst`  in  3  destination index; 0–3 = AX..DX, 4–7 = SP,BP,DI,SI.
- `cmd_src`  in  3  source index; MOVE and SWAP only.
- `cmd_data`  in  DW  write data; WRITE only.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  DW  result word.
- `rsp_err`  out  1  command rejected.
- `rf_en`, `rf_wr`, `rf_rd1`, `rf_rd2`  out  1 each  register-file strobes.
- `rf_sel`  out  2  register-file select.
- `rf_wdata`  out  DW  register-file write data.
- `rf_rdata`  in  DW  register-file read result, combinational from strobes.
- `err_count`  out  8  saturating count of rejected commands.

## Operation
- FSM states and transitions:
  - IDLE → RD_A (READ, MOVE, SWAP).
  - IDLE → WR_A (WRITE).
  - IDLE → RESP (error).
  - RD_A → RD_B (SWAP), otherwise → WR_A (MOVE) or → RESP (READ).
  - RD_B → WR_A.
  - WR_A → WR_B (SWAP), otherwise → RESP.
  - WR_B → RESP.
  - RESP → IDLE when `rsp_ready` is high.
- Index mapping:
  - `rf_sel` = idx[1:0].
  - A read drives `rf_rd1` when idx[2]=0 and `rf_rd2` when idx[2]=1.
  - Writes are legal only to idx 0–3.
- Strobe rules:
  - `rf_en` is high only in RD_A, RD_B, WR_A and WR_B.
  - Exactly one of `rf_rd1`, `rf_rd2`, `rf_wr` is high in each of those states; all strobes are 0 in every other state.
- Phase actions:
  - READ: RD_A reads dst; `rf_rdata` is captured into tmpA.
  - WRITE: WR_A writes `cmd_data` to dst.
  - MOVE: RD_A reads src into tmpA; WR_A writes tmpA to dst.
  - SWAP: RD_A reads src into tmpA; RD_B reads dst into tmpB; WR_A writes tmpA to dst; WR_B writes tmpB to src.
- Response data: READ and MOVE return tmpA; WRITE returns `cmd_data`; SWAP returns tmpB (the old dst value).
- Errors:
  - Conditions: WRITE, MOVE or SWAP with dst ≥ 4, or SWAP with src ≥ 4.
  - Response: `rsp_err`=1, `rsp_data`=0, and no register-file strobe is issued.
  - `err_count` increments on entry to RESP with an error and saturates at 255.
- SWAP with src == dst is legal and leaves the register value unchanged.
- Command fields are latched at acceptance; later changes on the `cmd_*` inputs are ignored.

## Timing
- Reset values:
  - State is IDLE.
  - `cmd_ready`, `rsp_valid`, `rsp_err`, all `rf_*` outputs, `rsp_data`, tmpA, tmpB and `err_count` are all 0.
- `cmd_ready` is registered and rises on the first clock edge after `rst` deasserts.
- `cmd_ready` is high only in IDLE, and a command is accepted on an edge where `cmd_valid` and `cmd_ready` are both high.
- Commands never overlap: no command is accepted while a response is pending.
- Latency, counted in edges from acceptance to `rsp_valid` high:
  - READ: 2.
  - WRITE: 2.
  - MOVE: 3.
  - SWAP: 5.
  - Error: 1.
- `rsp_valid`, `rsp_data` and `rsp_err` stay stable until the edge where `rsp_ready` is high.
- `cmd_ready` rises on the same edge that the response is consumed, so back-to-back commands have one idle-handshake cycle between them.
- `rf_rdata` is sampled at the end of each read cycle.
- A write takes effect in the register file during the WR cycle.
- Reset mid-operation:
  - All strobes drop immediately (asynchronously).
  - The pending response is discarded.
  - A partially completed SWAP is not rolled back.

## Structure
- Shared package `regfile_pkg`:
  - op encodings.
  - state enum.
  - register index constants AX=0 … SI=7.
  - `DW` default.
- Optional sub-module `rf_port_decode` (combinational): maps {phase, index} to `rf_rd1`, `rf_rd2`, `rf_wr` and `rf_sel`.
- The FSM, temporaries and error counter stay in the top module.

## Test plan
- After reset: WRITE dst=0, data=16'h1234; then READ dst=0 → `rsp_data`=16'h1234, `rsp_err`=0, READ latency 2 edges.
- MOVE src=0 (16'h1234), dst=3 → DX=16'h1234, `rsp_data`=16'h1234; exactly one `rf_rd1` cycle and one `rf_wr` cycle with `rf_sel`=3.
- With AX=16'h00AA and BX=16'h00BB: SWAP src=0, dst=1 → AX=16'h00BB, BX=16'h00AA, `rsp_data`=16'h00BB, latency 5 edges.
- WRITE dst=5 → `rsp_err`=1, `rsp_data`=0, no `rf_en` pulse, `err_count` becomes 1; 256 such errors → `err_count` holds at 255.
- READ dst=6 with `rsp_ready` held low for 4 cycles → `rf_rd2`=1 and `rf_sel`=2 in RD_A; response stays stable; `cmd_ready` stays 0 until the handshake.
- Assert `rst` during RD_B of a SWAP → all `rf_*` outputs and `rsp_valid` go to 0 immediately; `cmd_ready`=1 one edge after `rst` is released.
